// File: rtl/decode_scoreboard.sv
// decode_scoreboard
//   Registered decode/issue stage between the fetch/D pipeline register and
//   execute. Decodes RV32I, reads operands from an internal register file and
//   tracks in-flight writes per register with a small pending-write counter.
//   A source-operand hazard stalls until the producer writes back; there is no
//   forwarding from later stages.
//
// Optional build macro: DECODE_SB_WB_BYPASS_EN
//   When defined, a source whose last pending write lands in the same cycle is
//   taken straight from wb_val_i, which removes the one-cycle bubble.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   f_valid_i/f_ready_o, f_instr_i, f_pc_i   fetch side handshake and payload
//   d_valid_o/d_ready_i, d_pc_o, d_opcode_info_o, d_rd_o, d_wen_o, d_imm_o,
//   d_valA_o, d_valB_o                        execute side handshake and payload
//   flush_i          drop the held instruction and block accept this cycle
//   wb_valid_i, wb_rd_i, wb_val_i             register writeback
//   kill_valid_i, kill_rd_i                   squashed producer, no writeback
//   sb_busy_o        some register has a pending write
//   sb_err_o         sticky: a counter was decremented below zero
module decode_scoreboard #(
  parameter int WIDTH     = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_WIDTH = 5,
  parameter int CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_valid_i,
  output logic                 f_ready_o,
  input  logic [WIDTH-1:0]     f_instr_i,
  input  logic [WIDTH-1:0]     f_pc_i,
  output logic                 d_valid_o,
  input  logic                 d_ready_i,
  output logic [WIDTH-1:0]     d_pc_o,
  output logic [9:0]           d_opcode_info_o,
  output logic [REG_WIDTH-1:0] d_rd_o,
  output logic                 d_wen_o,
  output logic [WIDTH-1:0]     d_imm_o,
  output logic [WIDTH-1:0]     d_valA_o,
  output logic [WIDTH-1:0]     d_valB_o,
  input  logic                 flush_i,
  input  logic                 wb_valid_i,
  input  logic [REG_WIDTH-1:0] wb_rd_i,
  input  logic [WIDTH-1:0]     wb_val_i,
  input  logic                 kill_valid_i,
  input  logic [REG_WIDTH-1:0] kill_rd_i,
  output logic                 sb_busy_o,
  output logic                 sb_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]     r_rf  [NUM_REGS];
  logic [CNT_W-1:0]     r_cnt [NUM_REGS];
  logic [CNT_W-1:0]     w_cnt_nxt [NUM_REGS];
  logic [CNT_W+1:0]     w_sum;
  logic                 w_err_set;

  logic [6:0]           w_opcode;
  logic [2:0]           w_f3;
  logic [REG_WIDTH-1:0] w_rd, w_rs1, w_rs2;
  logic [9:0]           w_info;
  logic                 w_alu_imm, w_alu, w_branch, w_jal, w_jalr;
  logic                 w_load, w_store, w_lui, w_auipc, w_system;
  logic                 w_csr, w_csr_reg;
  logic                 w_need_rs1, w_need_rs2, w_need_rd, w_wen;
  logic [31:0]          w_imm32;
  logic                 w_bypA, w_bypB, w_hazA, w_hazB, w_waw, w_hazard;
  logic [WIDTH-1:0]     w_valA, w_valB;
  logic                 w_accept;

  assign w_opcode = f_instr_i[6:0];
  assign w_f3     = f_instr_i[14:12];
  assign w_rd     = f_instr_i[7 +: REG_WIDTH];
  assign w_rs1    = f_instr_i[15 +: REG_WIDTH];
  assign w_rs2    = f_instr_i[20 +: REG_WIDTH];

  always_comb begin
    w_info = '0;
    case (w_opcode)
      7'b0010011: w_info[9] = 1'b1;
      7'b0110011: w_info[8] = 1'b1;
      7'b1100011: w_info[7] = 1'b1;
      7'b1101111: w_info[6] = 1'b1;
      7'b1100111: w_info[5] = 1'b1;
      7'b0000011: w_info[4] = 1'b1;
      7'b0100011: w_info[3] = 1'b1;
      7'b0110111: w_info[2] = 1'b1;
      7'b0010111: w_info[1] = 1'b1;
      7'b1110011: w_info[0] = 1'b1;
      default:    w_info    = '0;
    endcase
  end

  assign {w_alu_imm, w_alu, w_branch, w_jal, w_jalr,
          w_load, w_store, w_lui, w_auipc, w_system} = w_info;

  // funct3==0 under SYSTEM is ecall/ebreak/mret; funct3[2] marks CSR-immediate.
  assign w_csr      = w_system & (w_f3 != 3'b000);
  assign w_csr_reg  = w_csr & ~w_f3[2];
  assign w_need_rs1 = w_alu_imm | w_alu | w_branch | w_jalr | w_load | w_store | w_csr_reg;
  assign w_need_rs2 = w_alu | w_branch | w_store;
  assign w_need_rd  = w_alu_imm | w_alu | w_jal | w_jalr | w_load | w_lui | w_auipc | w_csr;
  assign w_wen      = w_need_rd & (w_rd != '0);

  always_comb begin
    w_imm32 = '0;
    if (w_alu_imm | w_jalr | w_load)
      w_imm32 = {{20{f_instr_i[31]}}, f_instr_i[31:20]};
    else if (w_store)
      w_imm32 = {{20{f_instr_i[31]}}, f_instr_i[31:25], f_instr_i[11:7]};
    else if (w_branch)
      w_imm32 = {{19{f_instr_i[31]}}, f_instr_i[31], f_instr_i[7],
                 f_instr_i[30:25], f_instr_i[11:8], 1'b0};
    else if (w_jal)
      w_imm32 = {{11{f_instr_i[31]}}, f_instr_i[31], f_instr_i[19:12],
                 f_instr_i[20], f_instr_i[30:21], 1'b0};
    else if (w_lui | w_auipc)
      w_imm32 = {f_instr_i[31:12], 12'b0};
  end

`ifdef DECODE_SB_WB_BYPASS_EN
  // Last outstanding write arriving now: take the operand from the wb bus.
  assign w_bypA = wb_valid_i & (wb_rd_i == w_rs1) & (r_cnt[w_rs1] == CNT_W'(1));
  assign w_bypB = wb_valid_i & (wb_rd_i == w_rs2) & (r_cnt[w_rs2] == CNT_W'(1));
`else
  assign w_bypA = 1'b0;
  assign w_bypB = 1'b0;
`endif

  assign w_hazA   = w_need_rs1 & (w_rs1 != '0) & (r_cnt[w_rs1] != '0) & ~w_bypA;
  assign w_hazB   = w_need_rs2 & (w_rs2 != '0) & (r_cnt[w_rs2] != '0) & ~w_bypB;
  assign w_waw    = w_wen & (r_cnt[w_rd] == CNT_MAX);
  assign w_hazard = w_hazA | w_hazB | w_waw;

  assign w_valA = (w_rs1 == '0) ? '0 : (w_bypA ? wb_val_i : r_rf[w_rs1]);
  assign w_valB = (w_rs2 == '0) ? '0 : (w_bypB ? wb_val_i : r_rf[w_rs2]);

  assign f_ready_o = (~d_valid_o | d_ready_i) & ~w_hazard & ~flush_i;
  assign w_accept  = f_valid_i & f_ready_o;

  // Net counter change per register; flush and accept are mutually exclusive.
  always_comb begin
    w_err_set = 1'b0;
    w_sum     = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_sum = {2'b00, r_cnt[i]}
            + {{(CNT_W+1){1'b0}}, (w_accept & w_wen & (w_rd == REG_WIDTH'(i)))}
            - {{(CNT_W+1){1'b0}}, (wb_valid_i & (wb_rd_i != '0) & (wb_rd_i == REG_WIDTH'(i)))}
            - {{(CNT_W+1){1'b0}}, (kill_valid_i & (kill_rd_i != '0) & (kill_rd_i == REG_WIDTH'(i)))}
            - {{(CNT_W+1){1'b0}}, (flush_i & d_valid_o & d_wen_o & (d_rd_o == REG_WIDTH'(i)))};
      if (w_sum[CNT_W+1]) begin
        w_cnt_nxt[i] = '0;
        w_err_set    = 1'b1;
      end else begin
        w_cnt_nxt[i] = w_sum[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    sb_busy_o = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      sb_busy_o = sb_busy_o | (r_cnt[i] != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_rf[i]  <= '0;
        r_cnt[i] <= '0;
      end
      sb_err_o <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        r_cnt[i] <= w_cnt_nxt[i];
      if (wb_valid_i && (wb_rd_i != '0))
        r_rf[wb_rd_i] <= wb_val_i;
      if (w_err_set)
        sb_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid_o       <= 1'b0;
      d_pc_o          <= '0;
      d_opcode_info_o <= '0;
      d_rd_o          <= '0;
      d_wen_o         <= 1'b0;
      d_imm_o         <= '0;
      d_valA_o        <= '0;
      d_valB_o        <= '0;
    end else if (w_accept) begin
      d_valid_o       <= 1'b1;
      d_pc_o          <= f_pc_i;
      d_opcode_info_o <= w_info;
      d_rd_o          <= w_need_rd ? w_rd : '0;
      d_wen_o         <= w_wen;
      d_imm_o         <= WIDTH'(w_imm32);
      d_valA_o        <= w_valA;
      d_valB_o        <= w_valB;
    end else if (flush_i || d_ready_i) begin
      d_valid_o       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
module tb_decode_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        f_valid_i = 1'b0;
  logic        f_ready_o;
  logic [31:0] f_instr_i = '0;
  logic [31:0] f_pc_i = '0;
  logic        d_valid_o;
  logic        d_ready_i = 1'b1;
  logic [31:0] d_pc_o;
  logic [9:0]  d_opcode_info_o;
  logic [4:0]  d_rd_o;
  logic        d_wen_o;
  logic [31:0] d_imm_o;
  logic [31:0] d_valA_o;
  logic [31:0] d_valB_o;
  logic        flush_i = 1'b0;
  logic        wb_valid_i = 1'b0;
  logic [4:0]  wb_rd_i = '0;
  logic [31:0] wb_val_i = '0;
  logic        kill_valid_i = 1'b0;
  logic [4:0]  kill_rd_i = '0;
  logic        sb_busy_o;
  logic        sb_err_o;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADD_X2  = 32'h0010_8133; // add  x2,x1,x1
  localparam logic [31:0] I_SW_X1   = 32'h0010_2623; // sw   x1,12(x0)
  localparam logic [31:0] I_ADDI_X3 = 32'h0010_0193; // addi x3,x0,1
  localparam logic [31:0] I_LW_X4   = 32'h0080_2203; // lw   x4,8(x0)
  localparam logic [31:0] I_LUI_X6  = 32'h1234_5337; // lui  x6,0x12345
  localparam logic [31:0] I_BEQ     = 32'h0000_0463; // beq  x0,x0,8
  localparam logic [31:0] I_JAL_M4  = 32'hFFDF_F06F; // jal  x0,-4

  decode_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .f_valid_i       (f_valid_i),
    .f_ready_o       (f_ready_o),
    .f_instr_i       (f_instr_i),
    .f_pc_i          (f_pc_i),
    .d_valid_o       (d_valid_o),
    .d_ready_i       (d_ready_i),
    .d_pc_o          (d_pc_o),
    .d_opcode_info_o (d_opcode_info_o),
    .d_rd_o          (d_rd_o),
    .d_wen_o         (d_wen_o),
    .d_imm_o         (d_imm_o),
    .d_valA_o        (d_valA_o),
    .d_valB_o        (d_valB_o),
    .flush_i         (flush_i),
    .wb_valid_i      (wb_valid_i),
    .wb_rd_i         (wb_rd_i),
    .wb_val_i        (wb_val_i),
    .kill_valid_i    (kill_valid_i),
    .kill_rd_i       (kill_rd_i),
    .sb_busy_o       (sb_busy_o),
    .sb_err_o        (sb_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    f_valid_i = 1'b1;
    f_instr_i = instr;
    f_pc_i    = pc;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check_eq("rst_d_valid", 32'(d_valid_o), 32'd0);
    check_eq("rst_f_ready", 32'(f_ready_o), 32'd1);
    check_eq("rst_busy",    32'(sb_busy_o), 32'd0);
    check_eq("rst_err",     32'(sb_err_o),  32'd0);
    check_eq("rst_d_pc",    d_pc_o,         32'd0);
    tick();
    tick();
    mid();
    rst = 1'b0;

    // addi x1 issues, x1 becomes pending
    tick();
    issue(I_ADDI_X1, 32'h100);
    mid();
    check_eq("addi_f_ready", 32'(f_ready_o), 32'd1);
    tick();
    check_eq("addi_valid", 32'(d_valid_o), 32'd1);
    check_eq("addi_rd",    32'(d_rd_o), 32'd1);
    check_eq("addi_imm",   d_imm_o, 32'd5);
    check_eq("addi_wen",   32'(d_wen_o), 32'd1);
    check_eq("addi_pc",    d_pc_o, 32'h100);
    check_eq("addi_info",  32'(d_opcode_info_o), 32'h200);
    check_eq("addi_busy",  32'(sb_busy_o), 32'd1);

    // add x2,x1,x1 stalls on x1
    issue(I_ADD_X2, 32'h104);
    mid();
    check_eq("raw_stall_ready", 32'(f_ready_o), 32'd0);
    tick();
    check_eq("raw_stall_valid", 32'(d_valid_o), 32'd0);
    check_eq("raw_stall_busy",  32'(sb_busy_o), 32'd1);

    wb_valid_i = 1'b1; wb_rd_i = 5'd1; wb_val_i = 32'd5;
`ifdef DECODE_SB_WB_BYPASS_EN
    mid();
    check_eq("byp_ready", 32'(f_ready_o), 32'd1);
    tick();
    wb_valid_i = 1'b0;
    f_valid_i  = 1'b0;
`else
    mid();
    check_eq("wb_cycle_ready", 32'(f_ready_o), 32'd0);
    tick();
    check_eq("wb_cycle_valid", 32'(d_valid_o), 32'd0);
    wb_valid_i = 1'b0;
    mid();
    check_eq("bubble_ready", 32'(f_ready_o), 32'd1);
    tick();
    f_valid_i = 1'b0;
`endif
    check_eq("add_valid", 32'(d_valid_o), 32'd1);
    check_eq("add_valA",  d_valA_o, 32'd5);
    check_eq("add_valB",  d_valB_o, 32'd5);
    check_eq("add_rd",    32'(d_rd_o), 32'd2);
    check_eq("add_info",  32'(d_opcode_info_o), 32'h100);
    check_eq("add_pc",    d_pc_o, 32'h104);

    // retire x2
    wb_valid_i = 1'b1; wb_rd_i = 5'd2; wb_val_i = 32'd10;
    tick();
    wb_valid_i = 1'b0;
    check_eq("x2_wb_valid", 32'(d_valid_o), 32'd0);
    check_eq("x2_wb_busy",  32'(sb_busy_o), 32'd0);

    // store: no rd, S immediate, rs2 from regfile
    issue(I_SW_X1, 32'h108);
    tick();
    f_valid_i = 1'b0;
    check_eq("sw_valid", 32'(d_valid_o), 32'd1);
    check_eq("sw_info",  32'(d_opcode_info_o), 32'h008);
    check_eq("sw_wen",   32'(d_wen_o), 32'd0);
    check_eq("sw_rd",    32'(d_rd_o), 32'd0);
    check_eq("sw_imm",   d_imm_o, 32'd12);
    check_eq("sw_valA",  d_valA_o, 32'd0);
    check_eq("sw_valB",  d_valB_o, 32'd5);
    check_eq("sw_busy",  32'(sb_busy_o), 32'd0);

    // WAW saturation on x3: three issue, fourth stalls
    issue(I_ADDI_X3, 32'h110);
    tick();
    tick();
    tick();
    mid();
    check_eq("waw_full_ready", 32'(f_ready_o), 32'd0);
    tick();
    check_eq("waw_full_valid", 32'(d_valid_o), 32'd0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd3; wb_val_i = 32'd7;
    mid();
    check_eq("waw_wb_ready", 32'(f_ready_o), 32'd0);
    tick();
    wb_valid_i = 1'b0;
    mid();
    check_eq("waw_after_wb_ready", 32'(f_ready_o), 32'd1);
    tick();
    check_eq("waw_fourth_valid", 32'(d_valid_o), 32'd1);
    check_eq("waw_fourth_rd",    32'(d_rd_o), 32'd3);
    f_valid_i = 1'b0;
    mid();
    check_eq("waw_back_to_max", 32'(f_ready_o), 32'd0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd3;
    tick();
    tick();
    tick();
    wb_valid_i = 1'b0;
    check_eq("waw_drained_busy", 32'(sb_busy_o), 32'd0);
    check_eq("waw_drained_err",  32'(sb_err_o), 32'd0);

    // flush of a held load
    d_ready_i = 1'b0;
    issue(I_LW_X4, 32'h200);
    tick();
    check_eq("lw_valid", 32'(d_valid_o), 32'd1);
    check_eq("lw_rd",    32'(d_rd_o), 32'd4);
    check_eq("lw_info",  32'(d_opcode_info_o), 32'h010);
    check_eq("lw_imm",   d_imm_o, 32'd8);
    check_eq("lw_busy",  32'(sb_busy_o), 32'd1);
    issue(I_LUI_X6, 32'h204);
    mid();
    check_eq("hold_ready", 32'(f_ready_o), 32'd0);
    tick();
    check_eq("hold_pc", d_pc_o, 32'h200);
    check_eq("hold_rd", 32'(d_rd_o), 32'd4);
    flush_i = 1'b1;
    mid();
    check_eq("flush_ready", 32'(f_ready_o), 32'd0);
    tick();
    flush_i   = 1'b0;
    f_valid_i = 1'b0;
    check_eq("flush_valid", 32'(d_valid_o), 32'd0);
    check_eq("flush_busy",  32'(sb_busy_o), 32'd0);
    check_eq("flush_err",   32'(sb_err_o), 32'd0);

    // kill of a register with nothing pending
    kill_valid_i = 1'b1; kill_rd_i = 5'd5;
    tick();
    kill_valid_i = 1'b0;
    check_eq("kill_err",  32'(sb_err_o), 32'd1);
    check_eq("kill_busy", 32'(sb_busy_o), 32'd0);
    tick();
    check_eq("kill_err_sticky", 32'(sb_err_o), 32'd1);

    // held lui, then asynchronous reset mid-cycle
    issue(I_LUI_X6, 32'h300);
    tick();
    f_valid_i = 1'b0;
    check_eq("lui_valid", 32'(d_valid_o), 32'd1);
    check_eq("lui_imm",   d_imm_o, 32'h1234_5000);
    check_eq("lui_rd",    32'(d_rd_o), 32'd6);
    check_eq("lui_busy",  32'(sb_busy_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(d_valid_o), 32'd0);
    check_eq("arst_imm",   d_imm_o, 32'd0);
    check_eq("arst_pc",    d_pc_o, 32'd0);
    check_eq("arst_rd",    32'(d_rd_o), 32'd0);
    check_eq("arst_busy",  32'(sb_busy_o), 32'd0);
    check_eq("arst_err",   32'(sb_err_o), 32'd0);
    mid();
    rst = 1'b0;

    // beq x0,x0 while writeback targets x0
    d_ready_i  = 1'b1;
    wb_valid_i = 1'b1; wb_rd_i = 5'd0; wb_val_i = 32'hDEAD;
    tick();
    issue(I_BEQ, 32'h400);
    mid();
    check_eq("beq_ready", 32'(f_ready_o), 32'd1);
    tick();
    wb_valid_i = 1'b0;
    check_eq("beq_valid", 32'(d_valid_o), 32'd1);
    check_eq("beq_valA",  d_valA_o, 32'd0);
    check_eq("beq_valB",  d_valB_o, 32'd0);
    check_eq("beq_wen",   32'(d_wen_o), 32'd0);
    check_eq("beq_rd",    32'(d_rd_o), 32'd0);
    check_eq("beq_imm",   d_imm_o, 32'd8);
    check_eq("beq_info",  32'(d_opcode_info_o), 32'h080);
    check_eq("beq_busy",  32'(sb_busy_o), 32'd0);

    // jal x0 with negative offset
    issue(I_JAL_M4, 32'h404);
    tick();
    f_valid_i = 1'b0;
    check_eq("jal_imm",  d_imm_o, 32'hFFFF_FFFC);
    check_eq("jal_info", 32'(d_opcode_info_o), 32'h040);
    check_eq("jal_rd",   32'(d_rd_o), 32'd0);
    check_eq("jal_wen",  32'(d_wen_o), 32'd0);
    check_eq("jal_pc",   d_pc_o, 32'h404);
    tick();
    check_eq("drain_valid", 32'(d_valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
